// File: rtl/mmcm_drp_pkg.sv
// mmcm_drp_pkg
//   Shared definitions for the MMCME4 DRP reconfiguration controller.
//   Contents:
//     state_t              controller FSM states
//     STATUS_*             completion status codes reported with done
//     CLKREG1/2_KEEP       read-modify-write preserve masks
//     *_LSB / *_BIT        bit positions of the divide fields
//     clkreg_addr()        per-channel ClkReg1/ClkReg2 DRP address table
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_HOLD  = 4'd1,
        ST_SEL       = 4'd2,
        ST_RD_REQ    = 4'd3,
        ST_RD_WAIT   = 4'd4,
        ST_WR_REQ    = 4'd5,
        ST_WR_WAIT   = 4'd6,
        ST_RELEASE   = 4'd7,
        ST_LOCK_WAIT = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

    localparam logic [1:0] STATUS_OK           = 2'd0;
    localparam logic [1:0] STATUS_BAD_DIV      = 2'd1;
    localparam logic [1:0] STATUS_LOCK_TIMEOUT = 2'd2;

    // Bits kept from the value read back before the merged word is written.
    localparam logic [15:0] CLKREG1_KEEP = 16'hF000;
    localparam logic [15:0] CLKREG2_KEEP = 16'hFF3F;

    localparam int HIGH_LSB     = 6;   // ClkReg1 [11:6]
    localparam int LOW_LSB      = 0;   // ClkReg1 [5:0]
    localparam int EDGE_BIT     = 7;   // ClkReg2 [7]
    localparam int NO_COUNT_BIT = 6;   // ClkReg2 [6]

    localparam int MAX_DIV = 128;

    // ClkReg1 sits at the even base address, ClkReg2 directly above it.
    // CLKOUT5 is out of sequence in the MMCME4 register map.
    function automatic logic [6:0] clkreg_addr(input logic [2:0] ch, input logic reg_idx);
        logic [6:0] base;
        case (ch)
            3'd0:    base = 7'h08;
            3'd1:    base = 7'h0A;
            3'd2:    base = 7'h0C;
            3'd3:    base = 7'h0E;
            3'd4:    base = 7'h10;
            3'd5:    base = 7'h06;
            default: base = 7'h12;
        endcase
        return base | {6'd0, reg_idx};
    endfunction

endpackage

// File: rtl/mmcm_div_encode.sv
// mmcm_div_encode
//   Combinational translation of an integer CLKOUT divide into the MMCM
//   counter fields. The 6-bit HIGH/LOW fields wrap, so a count of 64 is
//   encoded as 0.
//   Ports:
//     div       in   DIV_W  integer divide value (1..128 expected)
//     high      out  6      HIGH time count
//     low       out  6      LOW time count
//     edge_bit  out  1      EDGE (odd divide)
//     no_count  out  1      NO_COUNT (bypass, divide by one)
module mmcm_div_encode #(
    parameter int DIV_W = 8
) (
    input  logic [DIV_W-1:0] div,
    output logic [5:0]       high,
    output logic [5:0]       low,
    output logic             edge_bit,
    output logic             no_count
);

    logic [15:0] d16;

    assign d16 = 16'(div);

    always_comb begin
        if (d16 == 16'd1) begin
            // Divide by one bypasses the counter; HIGH/LOW must still be non-zero.
            high     = 6'd1;
            low      = 6'd1;
            edge_bit = 1'b0;
            no_count = 1'b1;
        end else begin
            high     = 6'(d16 >> 1);
            low      = 6'(d16 - (d16 >> 1));
            edge_bit = d16[0];
            no_count = 1'b0;
        end
    end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig
//   Runtime reconfiguration of up to NUM_CH MMCME4 CLKOUT integer divides.
//   Holds the MMCM in reset, read-modify-writes ClkReg1/ClkReg2 of every
//   selected channel over DRP, releases reset and waits for LOCKED.
//   Optional build macro: MMCM_LOCK_TIMEOUT_EN bounds the lock wait by
//   LOCK_TIMEOUT cycles and reports status 2 on expiry.
//   Ports:
//     clk_in0    in   controller / DRP clock
//     reset      in   synchronous active-high reset
//     cfg_valid  in   configuration request
//     cfg_ready  out  high in IDLE, request accepted on cfg_valid & cfg_ready
//     cfg_div    in   per-channel divide, channel i at [i*DIV_W +: DIV_W]
//     cfg_mask   in   channel i rewritten when bit i is set
//     busy       out  high from accept through the done cycle
//     done       out  one-cycle completion pulse
//     status     out  0 ok, 1 bad divide, 2 lock timeout; held until next accept
//     mmcm_rst   out  MMCM RST
//     locked     in   MMCM LOCKED (already synchronous)
//     drp_*           DRP master port
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int DIV_W        = 8,
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                    clk_in0,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH-1:0]       cfg_mask,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status,
    output logic                    mmcm_rst,
    input  logic                    locked,
    output logic [6:0]              drp_daddr,
    output logic [15:0]             drp_di,
    input  logic [15:0]             drp_do,
    output logic                    drp_den,
    output logic                    drp_dwe,
    input  logic                    drp_drdy
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYC + 1);

    state_t                    state_reg, state_next;
    logic                      cfg_ready_reg, busy_reg, done_reg, mmcm_rst_reg;
    logic                      drp_den_reg, drp_dwe_reg;
    logic [1:0]                status_reg;
    logic [6:0]                drp_daddr_reg;
    logic [15:0]               drp_di_reg;
    logic [NUM_CH*DIV_W-1:0]   div_reg;
    logic [NUM_CH-1:0]         pending_reg;
    logic [2:0]                ch_reg;
    logic                      reg_idx_reg;
    logic [HOLD_W-1:0]         hold_cnt_reg;

    logic [NUM_CH-1:0]         bad_ch;
    logic                      accept;
    logic                      sel_found;
    logic [2:0]                sel_ch;
    logic [NUM_CH-1:0]         sel_onehot;
    logic [DIV_W-1:0]          cur_div;
    logic [5:0]                enc_high, enc_low;
    logic                      enc_edge, enc_no_count;
    logic [15:0]               merged_word;
    logic                      lock_expired;

`ifdef MMCM_LOCK_TIMEOUT_EN
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
    logic [LOCK_W-1:0] lock_cnt_reg;

    // lock_cnt_reg counts cycles since RELEASE, so expiry lands done
    // exactly LOCK_TIMEOUT cycles after mmcm_rst falls.
    assign lock_expired = (lock_cnt_reg + 1'b1) == LOCK_W'(LOCK_TIMEOUT);
`else
    assign lock_expired = 1'b0;
`endif

    // A channel is only checked when it is selected for rewrite.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_check
            logic [DIV_W-1:0] div_ch;
            assign div_ch     = cfg_div[gi*DIV_W +: DIV_W];
            assign bad_ch[gi] = cfg_mask[gi] &&
                                ((div_ch == '0) || (32'(div_ch) > 32'(MAX_DIV)));
        end
    endgenerate

    assign accept = (state_reg == ST_IDLE) && cfg_valid && cfg_ready_reg;

    // Lowest pending channel first.
    assign sel_found  = |pending_reg;
    assign sel_onehot = pending_reg & (~pending_reg + 1'b1);

    always_comb begin
        sel_ch = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_ch = 3'(i);
            end
        end
    end

    assign cur_div = div_reg[ch_reg*DIV_W +: DIV_W];

    mmcm_div_encode #(
        .DIV_W (DIV_W)
    ) u_div_encode (
        .div      (cur_div),
        .high     (enc_high),
        .low      (enc_low),
        .edge_bit (enc_edge),
        .no_count (enc_no_count)
    );

    // Merge is taken straight from the read data as drdy arrives, so the
    // captured word is already the value to be written back.
    always_comb begin
        if (!reg_idx_reg) begin
            merged_word = (drp_do & CLKREG1_KEEP)
                        | (16'(enc_high) << HIGH_LSB)
                        | (16'(enc_low)  << LOW_LSB);
        end else begin
            merged_word = (drp_do & CLKREG2_KEEP)
                        | (16'(enc_edge)     << EDGE_BIT)
                        | (16'(enc_no_count) << NO_COUNT_BIT);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (accept) state_next = (|bad_ch) ? ST_DONE : ST_RST_HOLD;
            ST_RST_HOLD:  if (hold_cnt_reg == HOLD_W'(RST_HOLD_CYC - 1)) state_next = ST_SEL;
            ST_SEL:       state_next = sel_found ? ST_RD_REQ : ST_RELEASE;
            ST_RD_REQ:    state_next = ST_RD_WAIT;
            ST_RD_WAIT:   if (drp_drdy) state_next = ST_WR_REQ;
            ST_WR_REQ:    state_next = ST_WR_WAIT;
            ST_WR_WAIT:   if (drp_drdy) state_next = reg_idx_reg ? ST_SEL : ST_RD_REQ;
            ST_RELEASE:   state_next = ST_LOCK_WAIT;
            ST_LOCK_WAIT: if (locked || lock_expired) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in0) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            status_reg    <= STATUS_OK;
            mmcm_rst_reg  <= 1'b1;
            drp_den_reg   <= 1'b0;
            drp_dwe_reg   <= 1'b0;
            drp_daddr_reg <= '0;
            drp_di_reg    <= '0;
            div_reg       <= '0;
            pending_reg   <= '0;
            ch_reg        <= '0;
            reg_idx_reg   <= 1'b0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            // Outputs follow the state being entered so they are registered
            // yet aligned with that state.
            cfg_ready_reg <= (state_next == ST_IDLE);
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= (state_next == ST_DONE);
            mmcm_rst_reg  <= state_next inside {ST_RST_HOLD, ST_SEL, ST_RD_REQ,
                                                ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT};
            drp_den_reg   <= (state_next == ST_RD_REQ) || (state_next == ST_WR_REQ);
            drp_dwe_reg   <= (state_next == ST_WR_REQ);

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        div_reg      <= cfg_div;
                        pending_reg  <= cfg_mask;
                        hold_cnt_reg <= '0;
                        status_reg   <= (|bad_ch) ? STATUS_BAD_DIV : STATUS_OK;
                    end
                end
                ST_RST_HOLD: begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end
                ST_SEL: begin
                    if (sel_found) begin
                        ch_reg        <= sel_ch;
                        reg_idx_reg   <= 1'b0;
                        pending_reg   <= pending_reg & ~sel_onehot;
                        drp_daddr_reg <= clkreg_addr(sel_ch, 1'b0);
                    end
                end
                ST_RD_WAIT: begin
                    if (drp_drdy) begin
                        drp_di_reg <= merged_word;
                    end
                end
                ST_WR_WAIT: begin
                    if (drp_drdy && !reg_idx_reg) begin
                        reg_idx_reg   <= 1'b1;
                        drp_daddr_reg <= clkreg_addr(ch_reg, 1'b1);
                    end
                end
                ST_LOCK_WAIT: begin
                    if (!locked && lock_expired) begin
                        status_reg <= STATUS_LOCK_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MMCM_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_in0) begin
        if (reset) begin
            lock_cnt_reg <= '0;
        end else if (state_reg == ST_RELEASE) begin
            lock_cnt_reg <= LOCK_W'(1);
        end else if (state_reg == ST_LOCK_WAIT) begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
        end
    end
`endif

    assign cfg_ready = cfg_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign status    = status_reg;
    assign mmcm_rst  = mmcm_rst_reg;
    assign drp_daddr = drp_daddr_reg;
    assign drp_di    = drp_di_reg;
    assign drp_den   = drp_den_reg;
    assign drp_dwe   = drp_dwe_reg;

endmodule
